// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared constants and state type for the SPI transaction sequencer
//
// Contents:
//   ADDR_*   register addresses on the SPI core's memory-mapped control port
//   ST_*     bit positions inside the core's STATUS register
//   CTRL_SSO CONTROL value that forces slave-select active
//   seq_state_e  transaction-level FSM states used by spi_xfer_sequencer

package spi_seq_pkg;

    localparam logic [2:0] ADDR_RXDATA   = 3'd0;
    localparam logic [2:0] ADDR_TXDATA   = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_CONTROL  = 3'd3;
    localparam logic [2:0] ADDR_SLAVESEL = 3'd5;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TMT  = 5;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;

    localparam logic [15:0] CTRL_SSO = 16'h0400;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SEL       = 4'd1,
        S_SSO_ON    = 4'd2,
        S_WAIT_TRDY = 4'd3,
        S_FETCH     = 4'd4,
        S_TX        = 4'd5,
        S_WAIT_RRDY = 4'd6,
        S_RX        = 4'd7,
        S_WAIT_TMT  = 4'd8,
        S_SSO_OFF   = 4'd9,
        S_CLR       = 4'd10,
        S_DONE      = 4'd11
    } seq_state_e;

endpackage

// File: rtl/spi_av_access.sv
// rtl/spi_av_access.sv - single register access on the SPI core's control port
//
// One request produces a 3-cycle access: two cycles with spi_select, mem_addr,
// the selected strobe and data_from_cpu held stable, then one idle cycle with
// strobes released. The requester must hold req/we/addr/wdata until ack.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req, we, addr, wdata    access request (we=1 write, we=0 read)
//   ack                     high in the second bus cycle; the edge ending it
//                           is the read-data capture edge
//   rdata                   core read data, valid while ack is high
//   spi_select, mem_addr, read_n, write_n, data_from_cpu  to the core
//   data_to_cpu             from the core

module spi_av_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic        read_n,
    output logic        write_n,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu
);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_CYC2 = 2'd1,
        P_GAP  = 2'd2
    } phase_e;

    phase_e phase_q, phase_d;
    logic   active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= P_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            P_IDLE:  if (req) phase_d = P_CYC2;
            P_CYC2:  phase_d = P_GAP;
            P_GAP:   phase_d = P_IDLE;
            default: phase_d = P_IDLE;
        endcase
    end

    // The first bus cycle is the cycle the request appears in, so the bus is
    // driven straight from the request while idle; the gap cycle ignores req.
    always_comb begin
        active        = (phase_q == P_IDLE && req) || (phase_q == P_CYC2);
        ack           = (phase_q == P_CYC2);
        rdata         = data_to_cpu;
        spi_select    = active;
        mem_addr      = active ? addr : 3'd0;
        read_n        = !(active && !we);
        write_n       = !(active && we);
        data_from_cpu = (active && we) ? wdata : 16'h0000;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - transaction-level front end for the 8-bit SPI master core
//
// Runs one header byte plus cmd_len data bytes under a single slave-select
// assertion, using spi_av_access for every register access.
// Optional build macro: SPI_SEQ_TIMEOUT_EN bounds every status wait to
// TIMEOUT_POLLS polls; on expiry the sequence skips to SSO_OFF with err set.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake (ready only in IDLE)
//   cmd_write, cmd_hdr, cmd_len         command fields, latched at acceptance
//   wdata/wvalid/wready                 write byte stream (wready only in FETCH)
//   rdata/rvalid                        read byte stream, single-cycle pulses
//   hdr_rx                              byte received in the header slot
//   done, err                           end-of-transaction pulse and status
//   busy                                high outside IDLE
//   spi_select, mem_addr, read_n,
//   write_n, data_from_cpu, data_to_cpu SPI core control port

module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int LEN_W         = 8,
    parameter int TIMEOUT_POLLS = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [7:0]       cmd_hdr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic [7:0]       rdata,
    output logic             rvalid,
    output logic [7:0]       hdr_rx,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             spi_select,
    output logic [2:0]       mem_addr,
    output logic             read_n,
    output logic             write_n,
    output logic [15:0]      data_from_cpu,
    input  logic [15:0]      data_to_cpu
);

    seq_state_e       state_q, state_d;
    logic [7:0]       hdr_q, hdr_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       hdr_rx_q, hdr_rx_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic             write_q, write_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;

    logic             acc_req, acc_we, acc_ack;
    logic [2:0]       acc_addr;
    logic [15:0]      acc_wdata, acc_rdata;
    logic [7:0]       status;
    logic             is_wait;
    logic             unused_rdata_hi;

    assign status          = acc_rdata[7:0];
    assign unused_rdata_hi = ^acc_rdata[15:8];
    assign is_wait         = (state_q == S_WAIT_TRDY) || (state_q == S_WAIT_RRDY) ||
                             (state_q == S_WAIT_TMT);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int POLL_W = $clog2(TIMEOUT_POLLS + 1);
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_POLLS;
`endif

    spi_av_access u_access (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (acc_req),
        .we            (acc_we),
        .addr          (acc_addr),
        .wdata         (acc_wdata),
        .ack           (acc_ack),
        .rdata         (acc_rdata),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            hdr_q      <= 8'h00;
            tx_byte_q  <= 8'h00;
            hdr_rx_q   <= 8'h00;
            rdata_q    <= 8'h00;
            len_cnt_q  <= '0;
            write_q    <= 1'b0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            tx_byte_q  <= tx_byte_d;
            hdr_rx_q   <= hdr_rx_d;
            rdata_q    <= rdata_d;
            len_cnt_q  <= len_cnt_d;
            write_q    <= write_d;
            first_q    <= first_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        tx_byte_d = tx_byte_q;
        hdr_rx_d  = hdr_rx_q;
        rdata_d   = rdata_q;
        len_cnt_d = len_cnt_q;
        write_d   = write_q;
        first_d   = first_q;
        err_d     = err_q;
        rvalid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d   = S_SEL;
                    hdr_d     = cmd_hdr;
                    len_cnt_d = cmd_len;
                    write_d   = cmd_write;
                    first_d   = 1'b1;
                    err_d     = 1'b0;
                end
            end
            S_SEL:    if (acc_ack) state_d = S_SSO_ON;
            S_SSO_ON: if (acc_ack) state_d = S_WAIT_TRDY;
            S_WAIT_TRDY: begin
                if (acc_ack && status[ST_TRDY]) begin
                    // Header slot sends the latched header; read slots send dummies.
                    tx_byte_d = first_q ? hdr_q : 8'h00;
                    state_d   = (!first_q && write_q) ? S_FETCH : S_TX;
                end
            end
            S_FETCH: begin
                if (wvalid) begin
                    tx_byte_d = wdata;
                    state_d   = S_TX;
                end
            end
            S_TX:        if (acc_ack) state_d = S_WAIT_RRDY;
            S_WAIT_RRDY: if (acc_ack && status[ST_RRDY]) state_d = S_RX;
            S_RX: begin
                if (acc_ack) begin
                    if (first_q) begin
                        hdr_rx_d = status;
                        first_d  = 1'b0;
                        state_d  = (len_cnt_q == '0) ? S_WAIT_TMT : S_WAIT_TRDY;
                    end else begin
                        if (!write_q) begin
                            rdata_d  = status;
                            rvalid_d = 1'b1;
                        end
                        // Only decremented in a data slot, which exists only
                        // while the count is non-zero, so it never wraps.
                        len_cnt_d = len_cnt_q - LEN_W'(1);
                        state_d   = (len_cnt_q == LEN_W'(1)) ? S_WAIT_TMT : S_WAIT_TRDY;
                    end
                end
            end
            S_WAIT_TMT: if (acc_ack && status[ST_TMT]) state_d = S_SSO_OFF;
            S_SSO_OFF:  if (acc_ack) state_d = S_CLR;
            S_CLR:      if (acc_ack) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Overrun/underrun seen on any poll marks the whole transaction bad.
        if (is_wait && acc_ack && (status[ST_TOE] || status[ST_ROE])) begin
            err_d = 1'b1;
        end

`ifdef SPI_SEQ_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        if (is_wait && acc_ack) begin
            if (state_d != state_q) begin
                poll_cnt_d = '0;
            end else if (poll_cnt_q == POLL_W'(TIMEOUT_POLLS - 1)) begin
                state_d    = S_SSO_OFF;
                err_d      = 1'b1;
                poll_cnt_d = '0;
            end else begin
                poll_cnt_d = poll_cnt_q + POLL_W'(1);
            end
        end
`endif
    end

    always_comb begin
        acc_req   = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = ADDR_RXDATA;
        acc_wdata = 16'h0000;
        wready    = 1'b0;
        done      = 1'b0;
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_SEL: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = ADDR_SLAVESEL;
                acc_wdata = 16'h0001;
            end
            S_SSO_ON: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = ADDR_CONTROL;
                acc_wdata = CTRL_SSO;
            end
            S_WAIT_TRDY, S_WAIT_RRDY, S_WAIT_TMT: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_STATUS;
            end
            S_FETCH: wready = 1'b1;
            S_TX: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = ADDR_TXDATA;
                acc_wdata = {8'h00, tx_byte_q};
            end
            S_RX: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_RXDATA;
            end
            S_SSO_OFF: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = ADDR_CONTROL;
                acc_wdata = 16'h0000;
            end
            S_CLR: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = ADDR_STATUS;
                acc_wdata = 16'h0000;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign hdr_rx = hdr_rx_q;
    assign err    = err_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - self-checking bench for spi_xfer_sequencer with an SPI core model

module tb_spi_xfer_sequencer;

    localparam int BYTE_CLKS = 24;
    localparam int BUDGET    = 20000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_hdr = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [7:0]  hdr_rx;
    logic        done;
    logic        err;
    logic        busy;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;

    always #5 clk = ~clk;

    spi_xfer_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_hdr(cmd_hdr), .cmd_len(cmd_len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .hdr_rx(hdr_rx),
        .done(done), .err(err), .busy(busy),
        .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n),
        .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboards: expected MOSI bytes, expected read bytes, slave reply bytes.
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] miso_q[$];
    logic [7:0] wq[$];

    // SPI core model
    bit          shifting, rrdy, roe_m, prev_wn, prev_rn;
    bit          force_roe = 0;
    bit          hold_trdy0 = 0;
    int          sh_cnt;
    logic [7:0]  rxbuf;
    logic [15:0] ctrl_r, ssel_r;
    logic [7:0]  status_m;
    logic        ss_n;
    logic [7:0]  e_byte;
    int          tx_cnt = 0, clr_cnt = 0, off_cnt = 0, poll_cnt = 0;

    assign ss_n     = !(ctrl_r[10] && ssel_r[0]);
    assign status_m = {rrdy, !shifting && !hold_trdy0, !shifting, 1'b0, roe_m | force_roe, 3'b000};
    assign data_to_cpu = (mem_addr == 3'd0) ? {8'h00, rxbuf} :
                         (mem_addr == 3'd2) ? {8'h00, status_m} :
                         (mem_addr == 3'd3) ? ctrl_r : 16'h0000;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shifting = 0; sh_cnt = 0; rrdy = 0; roe_m = 0; rxbuf = 8'h00;
            ctrl_r = 16'h0; ssel_r = 16'h0; prev_wn = 1; prev_rn = 1;
        end else begin
            if (shifting) begin
                sh_cnt--;
                if (sh_cnt == 0) begin
                    shifting = 0;
                    if (rrdy) roe_m = 1;
                    rrdy = 1;
                    if (miso_q.size() > 0) rxbuf = miso_q.pop_front();
                    else rxbuf = 8'hEE;
                end
            end
            if (!write_n && prev_wn) begin
                case (mem_addr)
                    3'd1: begin
                        tx_cnt++;
                        chk("ss_n_at_tx", ss_n, 0);
                        if (exp_mosi.size() > 0) begin
                            e_byte = exp_mosi.pop_front();
                            chk("mosi", data_from_cpu[7:0], e_byte);
                        end else chk("mosi_unexpected", exp_mosi.size(), 1);
                        shifting = 1; sh_cnt = BYTE_CLKS;
                    end
                    3'd2: begin clr_cnt++; roe_m = 0; end
                    3'd3: begin ctrl_r = data_from_cpu; if (data_from_cpu == 16'h0) off_cnt++; end
                    3'd5: ssel_r = data_from_cpu;
                    default: ;
                endcase
            end
            if (!read_n && prev_rn) begin
                if (mem_addr == 3'd2) poll_cnt++;
                if (mem_addr == 3'd0) rrdy = 0;
            end
            prev_wn = write_n;
            prev_rn = read_n;
        end
    end

    // Read-stream monitor and FETCH-stall observer
    int rv_cnt = 0, fetch_cyc = 0, ss_bad = 0;
    logic [7:0] e_rd;
    always @(negedge clk) begin
        if (reset_n) begin
            if (wready) begin fetch_cyc++; if (ss_n) ss_bad++; end
            if (rvalid) begin
                rv_cnt++;
                if (exp_rd.size() > 0) begin
                    e_rd = exp_rd.pop_front();
                    chk("rdata", rdata, e_rd);
                end else chk("rvalid_unexpected", rvalid, 0);
            end
        end
    end

    // Write-stream source with an optional stall before byte stall_idx
    int widx = 0, stall_idx = 0, stall_left = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (wvalid) begin
                void'(wq.pop_front());
                widx++;
                wvalid = 0;
            end else if (wready && wq.size() > 0) begin
                if (widx == stall_idx && stall_left > 0) stall_left--;
                else begin wvalid = 1; wdata = wq[0]; end
            end
        end
    end

    task automatic check_reset_vals(input string t);
        chk({t, "_cmd_ready"}, cmd_ready, 1);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_spi_select"}, spi_select, 0);
        chk({t, "_read_n"}, read_n, 1);
        chk({t, "_write_n"}, write_n, 1);
        chk({t, "_mem_addr"}, mem_addr, 0);
        chk({t, "_data_from_cpu"}, data_from_cpu, 0);
        chk({t, "_rvalid"}, rvalid, 0);
        chk({t, "_done"}, done, 0);
        chk({t, "_err"}, err, 0);
        chk({t, "_wready"}, wready, 0);
        chk({t, "_rdata"}, rdata, 0);
        chk({t, "_hdr_rx"}, hdr_rx, 0);
    endtask

    task automatic run_cmd(input bit wr, input logic [7:0] hdr, input int len, input bit exp_err,
                           input int exp_tx, input logic [7:0] exp_hdr, input bit chk_hdr);
        int tx0, rv0, clr0, off0, n, exp_rv;
        tx0 = tx_cnt; rv0 = rv_cnt; clr0 = clr_cnt; off0 = off_cnt;
        exp_rv = (wr || exp_tx == 0) ? 0 : len;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_hdr = hdr; cmd_len = len[7:0];
        @(posedge clk); #1;
        cmd_valid = 0;
        chk("sel_first_cycle", {spi_select, write_n, mem_addr, data_from_cpu},
            {1'b1, 1'b0, 3'd5, 16'h0001});
        n = 0;
        while (!done && n < BUDGET) begin @(negedge clk); n++; end
        chk("done_within_budget", done, 1);
        if (done) begin
            chk("err", err, exp_err);
            chk("cmd_ready_in_done", cmd_ready, 0);
            if (chk_hdr) chk("hdr_rx", hdr_rx, exp_hdr);
            chk("tx_bytes", tx_cnt - tx0, exp_tx);
            chk("rvalid_count", rv_cnt - rv0, exp_rv);
            chk("status_clear_before_done", clr_cnt - clr0, 1);
            chk("sso_off_before_done", off_cnt - off0, 1);
            chk("mosi_left", exp_mosi.size(), 0);
            chk("rdata_left", exp_rd.size(), 0);
            @(negedge clk);
            chk("done_single_pulse", done, 0);
            chk("idle_after_done", cmd_ready, 1);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] hdr;
        int         len;
        logic [7:0] wd[4];
        logic [7:0] rx[4];
        int         stall_idx;
        int         stall_n;
    } vec_t;

    vec_t tbl[4];

    task automatic run_vec(input vec_t v);
        int fc0, bad0;
        exp_mosi.push_back(v.hdr);
        for (int i = 0; i < v.len; i++) exp_mosi.push_back(v.wr ? v.wd[i] : 8'h00);
        for (int i = 0; i <= v.len; i++) miso_q.push_back(v.rx[i]);
        if (!v.wr) for (int i = 1; i <= v.len; i++) exp_rd.push_back(v.rx[i]);
        wq.delete();
        if (v.wr) for (int i = 0; i < v.len; i++) wq.push_back(v.wd[i]);
        widx = 0; stall_idx = v.stall_idx; stall_left = v.stall_n;
        fc0 = fetch_cyc; bad0 = ss_bad;
        run_cmd(v.wr, v.hdr, v.len, 1'b0, v.len + 1, v.rx[0], 1'b1);
        if (v.stall_n > 0) begin
            chk("fetch_stall_seen", (fetch_cyc - fc0) >= v.stall_n, 1);
            chk("ss_low_during_stall", ss_bad - bad0, 0);
        end
    endtask

    initial begin
        int n, tx0;
        tbl[0] = '{1'b0, 8'h90, 2, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'hA5, 8'h3C, 8'hC3, 8'h00}, 0, 0};
        tbl[1] = '{1'b1, 8'h12, 3, '{8'h01, 8'h02, 8'h03, 8'h00}, '{8'h11, 8'h22, 8'h33, 8'h44}, 1, 50};
        tbl[2] = '{1'b0, 8'hFF, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h5A, 8'h00, 8'h00, 8'h00}, 0, 0};
        tbl[3] = '{1'b0, 8'h0B, 3, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h77, 8'h80, 8'h01, 8'hFE}, 0, 0};

        repeat (3) @(posedge clk);
        #1 check_reset_vals("por");
        @(negedge clk); reset_n = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Overrun reported by status: transaction completes with err.
        force_roe = 1;
        exp_mosi.push_back(8'h33); exp_mosi.push_back(8'h00);
        miso_q.push_back(8'h44); miso_q.push_back(8'h55);
        exp_rd.push_back(8'h55);
        run_cmd(1'b0, 8'h33, 1, 1'b1, 2, 8'h44, 1'b1);
        force_roe = 0;
        run_vec(tbl[0]);

        // Maximum length: the byte counter must not wrap.
        exp_mosi.push_back(8'hC1);
        for (int i = 0; i < 255; i++) exp_mosi.push_back(8'h00);
        for (int i = 0; i < 256; i++) miso_q.push_back(8'(i * 7 + 3));
        for (int i = 1; i < 256; i++) exp_rd.push_back(8'(i * 7 + 3));
        run_cmd(1'b0, 8'hC1, 255, 1'b0, 256, 8'h03, 1'b1);

        // Asynchronous reset while waiting for RRDY in the header slot.
        exp_mosi.push_back(8'h90);
        miso_q.push_back(8'hAA);
        tx0 = tx_cnt;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_hdr = 8'h90; cmd_len = 8'd2;
        @(posedge clk); #1 cmd_valid = 0;
        n = 0;
        while (tx_cnt == tx0 && n < 2000) begin @(negedge clk); n++; end
        chk("rst_test_tx_seen", tx_cnt - tx0, 1);
        repeat (6) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        #2 reset_n = 0;
        #1 check_reset_vals("midrst");
        exp_mosi.delete(); exp_rd.delete(); miso_q.delete();
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        run_vec(tbl[3]);

`ifdef SPI_SEQ_TIMEOUT_EN
        begin
            int p0;
            hold_trdy0 = 1;
            p0 = poll_cnt;
            run_cmd(1'b0, 8'hAA, 0, 1'b1, 0, 8'h00, 1'b0);
            chk("timeout_poll_count", poll_cnt - p0, 1023);
            chk("timeout_sso_cleared", ctrl_r, 16'h0000);
            hold_trdy0 = 0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
